// File: rtl/vpu_fp_issue_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : vpu_fp_issue_ctrl
// Description : Credit-based issue front-end for a non-stallable FP unit with
//               an in-order result FIFO. Optional watchdog and protocol-error
//               flag are built when VPU_FP_ISSUE_WATCHDOG_EN is defined.
// Revision    : 1.0 - initial release
// =============================================================================
module vpu_fp_issue_ctrl #(
  parameter int OPERAND_WIDTH  = 16,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  // upstream operand port
  input  logic                     in_valid_i,
  input  logic [OPERAND_WIDTH-1:0] in_data_i,
  output logic                     in_ready_o,
  // FP unit port
  output logic                     unit_start_o,
  output logic [OPERAND_WIDTH-1:0] unit_op_o,
  input  logic                     unit_done_i,
  input  logic [OPERAND_WIDTH-1:0] unit_result_i,
  // downstream result port
  output logic                     out_valid_o,
  output logic [OPERAND_WIDTH-1:0] out_data_o,
  input  logic                     out_ready_i,
  // status
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

  logic [c_CNT_W-1:0]       r_outstanding;
  logic [c_CNT_W-1:0]       r_inflight;
  logic [c_CNT_W-1:0]       r_count;
  logic [c_PTR_W-1:0]       r_wr_ptr;
  logic [c_PTR_W-1:0]       r_rd_ptr;
  logic [OPERAND_WIDTH-1:0] r_mem [DEPTH];
  logic                     r_start;
  logic [OPERAND_WIDTH-1:0] r_op;

  logic w_accept;
  logic w_pop;
  logic w_done_ok;
  logic w_push;
  logic w_full;

  // Credit counts everything accepted and not yet popped, so the FIFO can
  // always absorb every result the FP unit will eventually deliver.
  assign in_ready_o   = ~rst & (r_outstanding < c_DEPTH_CNT);
  assign w_accept     = in_valid_i & in_ready_o;
  assign w_full       = (r_count == c_DEPTH_CNT);
  assign out_valid_o  = (r_count != c_CNT_ZERO);
  assign out_data_o   = r_mem[r_rd_ptr];
  assign w_pop        = out_valid_o & out_ready_i;
  assign w_done_ok    = unit_done_i & ((r_inflight != c_CNT_ZERO) | r_start);
  assign w_push       = w_done_ok & ~w_full;
  assign busy_o       = (r_outstanding != c_CNT_ZERO);
  assign unit_start_o = r_start;
  assign unit_op_o    = r_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start       <= 1'b0;
      r_op          <= '0;
      r_outstanding <= '0;
    end else begin
      r_start <= w_accept;
      if (w_accept) begin
        r_op <= in_data_i;
      end
      case ({w_accept, w_pop})
        2'b10:   r_outstanding <= r_outstanding + c_CNT_ONE;
        2'b01:   r_outstanding <= r_outstanding - c_CNT_ONE;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({r_start, w_done_ok})
        2'b10:   r_inflight <= r_inflight + c_CNT_ONE;
        2'b01:   r_inflight <= r_inflight - c_CNT_ONE;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads zero while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= unit_result_i;
    end
  end

`ifdef VPU_FP_ISSUE_WATCHDOG_EN
  localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES);
  localparam logic [c_WD_W-1:0] c_WD_ONE   = c_WD_W'(1);

  logic [c_WD_W-1:0] r_wd_cnt;
  logic              r_err;
  logic              w_spurious;

  assign w_spurious = unit_done_i & ~w_done_ok;
  assign err_o      = r_err;

  // Counter saturates at the limit; the error flag is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (unit_done_i || (r_inflight == c_CNT_ZERO)) begin
        r_wd_cnt <= '0;
      end else if (r_wd_cnt != c_WD_LIMIT) begin
        r_wd_cnt <= r_wd_cnt + c_WD_ONE;
      end
      if ((r_wd_cnt == c_WD_LIMIT) || w_spurious) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  localparam int c_unused_timeout = TIMEOUT_CYCLES;
  assign err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vpu_fp_issue_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : tb_vpu_fp_issue_ctrl
// Description : Self-checking bench: directed vector table, hand sequences and
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_vpu_fp_issue_ctrl;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;
`ifdef VPU_FP_ISSUE_WATCHDOG_EN
  localparam logic c_WD = 1'b1;
`else
  localparam logic c_WD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid_i;
  logic [W-1:0] in_data_i;
  logic         in_ready_o;
  logic         unit_start_o;
  logic [W-1:0] unit_op_o;
  logic         unit_done_i;
  logic [W-1:0] unit_result_i;
  logic         out_valid_o;
  logic [W-1:0] out_data_o;
  logic         out_ready_i;
  logic         busy_o;
  logic         err_o;

  int n_tests = 0;
  int n_fail  = 0;

  vpu_fp_issue_ctrl #(
    .OPERAND_WIDTH (W),
    .DEPTH         (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .unit_start_o (unit_start_o),
    .unit_op_o    (unit_op_o),
    .unit_done_i  (unit_done_i),
    .unit_result_i(unit_result_i),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_ready_i  (out_ready_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         iv;
    logic [W-1:0] id;
    logic         dn;
    logic [W-1:0] res;
    logic         ordy;
    logic         e_rdy;
    logic         e_start;
    logic [W-1:0] e_op;
    logic         e_val;
    logic [W-1:0] e_data;
    logic         e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [W-1:0] id, logic dn, logic [W-1:0] res,
                              logic ordy, logic e_rdy, logic e_start, logic [W-1:0] e_op,
                              logic e_val, logic [W-1:0] e_data, logic e_busy);
    vec_t v;
    v.iv = iv; v.id = id; v.dn = dn; v.res = res; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_start = e_start; v.e_op = e_op;
    v.e_val = e_val; v.e_data = e_data; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] id, input logic dn,
                       input logic [W-1:0] res, input logic ordy);
    in_valid_i    = iv;
    in_data_i     = id;
    unit_done_i   = dn;
    unit_result_i = res;
    out_ready_i   = ordy;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready_o, 0);
    chk({tag, "_start"}, unit_start_o, 0);
    chk({tag, "_op"}, unit_op_o, 0);
    chk({tag, "_out_valid"}, out_valid_o, 0);
    chk({tag, "_out_data"}, out_data_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  // Leaves the bench at posedge+1 with reset released and inputs idle.
  task automatic do_reset();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] fpu(input logic [W-1:0] op);
    return {op[7:0], op[15:8]} ^ 16'h1234;
  endfunction

  // Randomized traffic: the bench emulates a fixed-latency pipelined FP unit.
  task automatic rand_phase(input int lat, input int pv, input int pr, input int ncyc);
    int           m_out;
    logic [W-1:0] m_fifo[$];
    logic         m_start;
    logic [W-1:0] m_op;
    int           p_t[$];
    logic [W-1:0] p_r[$];
    logic         acc;
    logic         pop;
    do_reset();
    m_out   = 0;
    m_start = 1'b0;
    m_op    = '0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      in_valid_i  = ($urandom_range(99) < pv);
      in_data_i   = W'($urandom);
      out_ready_i = ($urandom_range(99) < pr);
      if (p_t.size() != 0 && p_t[0] == cyc) begin
        unit_done_i   = 1'b1;
        unit_result_i = p_r[0];
        void'(p_t.pop_front());
        void'(p_r.pop_front());
      end else begin
        unit_done_i   = 1'b0;
        unit_result_i = W'($urandom);
      end
      @(negedge clk);
      chk("rnd_in_ready", in_ready_o, m_out < DEPTH);
      chk("rnd_start", unit_start_o, m_start);
      if (m_start) chk("rnd_op", unit_op_o, m_op);
      chk("rnd_out_valid", out_valid_o, m_fifo.size() != 0);
      if (m_fifo.size() != 0) chk("rnd_out_data", out_data_o, m_fifo[0]);
      chk("rnd_busy", busy_o, m_out != 0);
      chk("rnd_err", err_o, 0);
      acc = in_valid_i && (m_out < DEPTH);
      pop = (m_fifo.size() != 0) && out_ready_i;
      if (m_start) begin
        p_t.push_back(cyc + lat);
        p_r.push_back(fpu(m_op));
      end
      if (pop) void'(m_fifo.pop_front());
      if (unit_done_i) m_fifo.push_back(unit_result_i);
      m_out   = m_out + (acc ? 1 : 0) - (pop ? 1 : 0);
      m_start = acc;
      if (acc) m_op = in_data_i;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0);

    // Single op followed by a four-deep credit stall and in-order drain.
    tbl.push_back(mk(1, 16'h4080, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'h4080, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'h4080, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'h4080, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'h4080, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 16'h0000, 1, 16'h3F00, 1, 1, 0, 16'h4080, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h4080, 1, 16'h3F00, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'h4080, 1, 16'h3F00, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h4080, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 16'h1111, 0, 16'h0000, 0, 1, 0, 16'h4080, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 16'h2222, 0, 16'h0000, 0, 1, 1, 16'h1111, 0, 16'h0000, 1));
    tbl.push_back(mk(1, 16'h3333, 0, 16'h0000, 0, 1, 1, 16'h2222, 0, 16'h0000, 1));
    tbl.push_back(mk(1, 16'h4444, 0, 16'h0000, 0, 1, 1, 16'h3333, 0, 16'h0000, 1));
    tbl.push_back(mk(1, 16'h5555, 0, 16'h0000, 0, 0, 1, 16'h4444, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 16'h0000, 1, 16'hA001, 0, 0, 0, 16'h4444, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 16'h0000, 1, 16'hA002, 0, 0, 0, 16'h4444, 1, 16'hA001, 1));
    tbl.push_back(mk(0, 16'h0000, 1, 16'hA003, 0, 0, 0, 16'h4444, 1, 16'hA001, 1));
    tbl.push_back(mk(0, 16'h0000, 1, 16'hA004, 0, 0, 0, 16'h4444, 1, 16'hA001, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h4444, 1, 16'hA001, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h4444, 1, 16'hA002, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'h4444, 1, 16'hA002, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'h4444, 1, 16'hA003, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'h4444, 1, 16'hA004, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h4444, 0, 16'h0000, 0));

    tick();
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].id, tbl[i].dn, tbl[i].res, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), in_ready_o, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_start", i), unit_start_o, tbl[i].e_start);
      chk($sformatf("tbl%0d_op", i), unit_op_o, tbl[i].e_op);
      chk($sformatf("tbl%0d_out_valid", i), out_valid_o, tbl[i].e_val);
      if (tbl[i].e_val) chk($sformatf("tbl%0d_out_data", i), out_data_o, tbl[i].e_data);
      chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].e_busy);
      tick();
    end

    // Start and done in the same cycle, then push and pop at count 1.
    do_reset();
    drive(1, 16'h0A0A, 0, 16'h0000, 0);
    @(negedge clk); chk("sim_in_ready", in_ready_o, 1); tick();
    drive(1, 16'h0B0B, 0, 16'h0000, 0);
    @(negedge clk); chk("sim_start_a", unit_start_o, 1); chk("sim_op_a", unit_op_o, 16'h0A0A); tick();
    drive(0, 16'h0000, 1, 16'hC0C0, 0);
    @(negedge clk); chk("sim_start_b", unit_start_o, 1); chk("sim_op_b", unit_op_o, 16'h0B0B); tick();
    drive(0, 16'h0000, 0, 16'h0000, 0);
    @(negedge clk); chk("sim_valid_a", out_valid_o, 1); chk("sim_data_a", out_data_o, 16'hC0C0); tick();
    drive(0, 16'h0000, 1, 16'hD0D0, 1);
    @(negedge clk); chk("sim_pushpop_data", out_data_o, 16'hC0C0); tick();
    drive(0, 16'h0000, 0, 16'h0000, 0);
    @(negedge clk); chk("sim_valid_b", out_valid_o, 1); chk("sim_data_b", out_data_o, 16'hD0D0);
    chk("sim_busy_b", busy_o, 1); tick();
    drive(0, 16'h0000, 0, 16'h0000, 1);
    @(negedge clk); chk("sim_valid_b2", out_valid_o, 1); tick();
    drive(0, 16'h0000, 0, 16'h0000, 0);
    @(negedge clk); chk("sim_empty", out_valid_o, 0); chk("sim_idle", busy_o, 0); tick();

    // Reset with three operations outstanding, then a late done pulse.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, W'(16'h0100 + i), 0, 16'h0000, 0);
      tick();
    end
    drive(0, 16'h0000, 1, 16'h7777, 0);
    tick();
    drive(0, 16'h0000, 0, 16'h0000, 0);
    @(negedge clk);
    chk("mid_busy", busy_o, 1);
    chk("mid_valid", out_valid_o, 1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("mid_rst");
    tick();
    rst = 1'b0;
    drive(0, 16'h0000, 1, 16'hEEEE, 1);
    tick();
    drive(0, 16'h0000, 0, 16'h0000, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("late%0d_valid", i), out_valid_o, 0);
      chk($sformatf("late%0d_busy", i), busy_o, 0);
      chk($sformatf("late%0d_in_ready", i), in_ready_o, 1);
      chk($sformatf("late%0d_err", i), err_o, c_WD);
      tick();
    end

    // Watchdog: one op whose result never arrives, then a spurious idle done.
    do_reset();
    drive(1, 16'h4242, 0, 16'h0000, 1);
    tick();
    drive(0, 16'h0000, 0, 16'h0000, 1);
    for (int i = 0; i < TMO + 16; i++) tick();
    @(negedge clk); chk("wd_err_set", err_o, c_WD); chk("wd_busy", busy_o, 1); tick();
    drive(0, 16'h0000, 1, 16'h1357, 1);
    tick();
    drive(0, 16'h0000, 0, 16'h0000, 1);
    tick(); tick();
    @(negedge clk); chk("wd_err_sticky", err_o, c_WD); chk("wd_drained", busy_o, 0); tick();
    do_reset();
    drive(0, 16'h0000, 1, 16'h2468, 1);
    tick();
    drive(0, 16'h0000, 0, 16'h0000, 1);
    tick();
    @(negedge clk);
    chk("spur_err", err_o, c_WD);
    chk("spur_valid", out_valid_o, 0);
    chk("spur_busy", busy_o, 0);
    tick();

    rand_phase(1, 70, 70, 400);
    rand_phase(3, 90, 40, 400);
    rand_phase(6, 100, 100, 300);
    rand_phase(6, 50, 90, 300);
    rand_phase(2, 100, 20, 300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
